// File: rtl/hdlc_rx_framer.sv
// HDLC receive framer: flag/abort detection, zero-bit destuffing and byte assembly.
// Data bits are taken from the far end of an 8-bit window, so delimiters are removed before assembly.
module hdlc_rx_framer (
    input  logic       Clk,
    input  logic       Rst,
    input  logic       Rx_Enable,
    input  logic       Rx,
    output logic       Rx_FlagDetect,
    output logic       Rx_AbortDetect,
    output logic       Rx_AbortSignal,
    output logic       Rx_ValidFrame,
    output logic [7:0] Rx_Data,
    output logic       Rx_NewByte,
    output logic       Rx_EoF,
    output logic       Rx_FrameError
);

    typedef enum logic [0:0] {StIdle, StFrame} state_e;

    localparam logic [7:0] FlagPattern  = 8'h7E;
    // Oldest bit (bit 0) is the 0, followed by seven 1s.
    localparam logic [7:0] AbortPattern = 8'hFE;

    // Input register and delimiter window.
    logic       rx_d_q;
    logic [7:0] win_q, win_d;
    logic [7:0] kill_q, kill_d;
    logic       dbit_q, dbit_d;
    logic       dkill_q, dkill_d;
    logic       flag_q, flag_d;
    logic       abort_q, abort_d;
    logic       flag_hit, abort_hit;

    // Frame state and byte assembly.
    state_e     state_q, state_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [2:0] ones_q, ones_d;
    logic [7:0] sr_q, sr_d;
    logic [7:0] data_q, data_d;
    logic       new_byte_q, new_byte_d;
    logic       seen_q, seen_d;
    logic       close_ok_q, close_ok_d;
    logic       close_err_q, close_err_d;
    logic       eof_q, eof_d;
    logic       ferr_q, ferr_d;
    logic       abort_sig_q, abort_sig_d;

    logic       in_frame, abort_now, close_now, data_valid, stuffed;

    // Window shifts toward bit 0; bits covered by a detected delimiter are tagged for removal.
    always_comb begin
        flag_hit  = (win_q == FlagPattern);
        abort_hit = (win_q == AbortPattern);
        win_d     = {rx_d_q, win_q[7:1]};
        kill_d    = {1'b0, kill_q[7:1] | {7{flag_hit | abort_hit}}};
        dbit_d    = win_q[0];
        dkill_d   = kill_q[0] | flag_hit | abort_hit;
        flag_d    = flag_hit;
        abort_d   = abort_hit;
    end

    always_comb begin
        in_frame   = (state_q == StFrame);
        abort_now  = in_frame && abort_q;
        close_now  = in_frame && flag_q && seen_q && !abort_now;
        data_valid = in_frame && !dkill_q && !abort_now && !close_now;
        stuffed    = data_valid && !dbit_q && (ones_q == 3'd5);

        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        ones_d      = ones_q;
        sr_d        = sr_q;
        data_d      = data_q;
        new_byte_d  = 1'b0;
        seen_d      = seen_q;
        close_ok_d  = 1'b0;
        close_err_d = 1'b0;
        abort_sig_d = 1'b0;
        eof_d       = close_ok_q && Rx_Enable;
        ferr_d      = close_err_q;

        unique case (state_q)
            StIdle: begin
                bit_cnt_d = 3'd0;
                ones_d    = 3'd0;
                seen_d    = 1'b0;
                if (flag_q) begin
                    state_d = StFrame;
                end
            end
            StFrame: begin
                if (abort_now) begin
                    // Abort wins over any byte completing now; the partial byte is dropped.
                    state_d     = StIdle;
                    abort_sig_d = 1'b1;
                    bit_cnt_d   = 3'd0;
                    ones_d      = 3'd0;
                    seen_d      = 1'b0;
                end else if (close_now) begin
                    state_d     = StIdle;
                    close_ok_d  = (bit_cnt_q == 3'd0);
                    close_err_d = (bit_cnt_q != 3'd0);
                    bit_cnt_d   = 3'd0;
                    ones_d      = 3'd0;
                    seen_d      = 1'b0;
                end else if (dkill_q || stuffed) begin
                    ones_d = 3'd0;
                end else if (data_valid) begin
                    if (dbit_q) begin
                        ones_d = (ones_q == 3'd7) ? ones_q : ones_q + 3'd1;
                    end else begin
                        ones_d = 3'd0;
                    end
                    sr_d      = {dbit_q, sr_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    seen_d    = 1'b1;
                    if (bit_cnt_q == 3'd7) begin
                        data_d     = {dbit_q, sr_q[7:1]};
                        new_byte_d = Rx_Enable;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            rx_d_q      <= 1'b1;
            win_q       <= 8'hFF;
            kill_q      <= 8'h00;
            dbit_q      <= 1'b1;
            dkill_q     <= 1'b1;
            flag_q      <= 1'b0;
            abort_q     <= 1'b0;
            state_q     <= StIdle;
            bit_cnt_q   <= 3'd0;
            ones_q      <= 3'd0;
            sr_q        <= 8'h00;
            data_q      <= 8'h00;
            new_byte_q  <= 1'b0;
            seen_q      <= 1'b0;
            close_ok_q  <= 1'b0;
            close_err_q <= 1'b0;
            eof_q       <= 1'b0;
            ferr_q      <= 1'b0;
            abort_sig_q <= 1'b0;
        end else begin
            rx_d_q      <= Rx;
            win_q       <= win_d;
            kill_q      <= kill_d;
            dbit_q      <= dbit_d;
            dkill_q     <= dkill_d;
            flag_q      <= flag_d;
            abort_q     <= abort_d;
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            ones_q      <= ones_d;
            sr_q        <= sr_d;
            data_q      <= data_d;
            new_byte_q  <= new_byte_d;
            seen_q      <= seen_d;
            close_ok_q  <= close_ok_d;
            close_err_q <= close_err_d;
            eof_q       <= eof_d;
            ferr_q      <= ferr_d;
            abort_sig_q <= abort_sig_d;
        end
    end

    assign Rx_FlagDetect  = flag_q;
    assign Rx_AbortDetect = abort_q;
    assign Rx_AbortSignal = abort_sig_q;
    assign Rx_ValidFrame  = (state_q == StFrame);
    assign Rx_Data        = data_q;
    assign Rx_NewByte     = new_byte_q;
    assign Rx_EoF         = eof_q;
    assign Rx_FrameError  = ferr_q;

endmodule

// File: tb/tb_hdlc_rx_framer.sv
// Directed bench for hdlc_rx_framer: table of framed bit streams with hand-computed
// event counts, data and edge timing, plus reset sequences.
module tb_hdlc_rx_framer;

    logic       Clk = 1'b0;
    logic       Rst = 1'b0;
    logic       Rx_Enable = 1'b1;
    logic       Rx = 1'b1;
    logic       Rx_FlagDetect, Rx_AbortDetect, Rx_AbortSignal, Rx_ValidFrame;
    logic [7:0] Rx_Data;
    logic       Rx_NewByte, Rx_EoF, Rx_FrameError;

    hdlc_rx_framer dut (
        .Clk            (Clk),
        .Rst            (Rst),
        .Rx_Enable      (Rx_Enable),
        .Rx             (Rx),
        .Rx_FlagDetect  (Rx_FlagDetect),
        .Rx_AbortDetect (Rx_AbortDetect),
        .Rx_AbortSignal (Rx_AbortSignal),
        .Rx_ValidFrame  (Rx_ValidFrame),
        .Rx_Data        (Rx_Data),
        .Rx_NewByte     (Rx_NewByte),
        .Rx_EoF         (Rx_EoF),
        .Rx_FrameError  (Rx_FrameError)
    );

    always #5 Clk = ~Clk;

    int cyc = 0;
    always @(posedge Clk) cyc <= cyc + 1;

    typedef struct {
        string      name;
        logic       en;
        int         n_open;      // opening flags
        int         n_bytes;     // 0 or 1 payload byte b
        logic [7:0] b;
        int         n_extra;     // extra data bits from e, LSB first
        logic [7:0] e;
        int         tail;        // 0 closing flag, 1 abort
        int         abort_ones;
        int         x_flag, x_abort, x_nb, x_eof, x_ferr, x_asig, x_fall;
        logic [7:0] x_data;
    } vec_t;

    int n_checks = 0;
    int n_fail = 0;

    int n_flag, n_abort, n_nb, n_eof, n_ferr, n_asig, n_fall, n_viol;
    int flag_cyc, abort_cyc, nb_cyc, eof_cyc, ferr_cyc, asig_cyc, fall_cyc;
    logic prev_vf;

    logic txq[$];
    int   ones, last_data;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic clear_stats();
        n_flag = 0; n_abort = 0; n_nb = 0; n_eof = 0; n_ferr = 0; n_asig = 0;
        n_fall = 0; n_viol = 0;
        flag_cyc = -1; abort_cyc = -1; nb_cyc = -1; eof_cyc = -1; ferr_cyc = -1;
        asig_cyc = -1; fall_cyc = -1;
        prev_vf = Rx_ValidFrame;
    endtask

    task automatic tick(input logic b);
        @(negedge Clk);
        Rx = b;
        @(posedge Clk);
        #1;
        if (Rx_FlagDetect) begin n_flag++; if (flag_cyc < 0) flag_cyc = cyc; end
        if (Rx_AbortDetect) begin n_abort++; if (abort_cyc < 0) abort_cyc = cyc; end
        if (Rx_NewByte) begin n_nb++; if (nb_cyc < 0) nb_cyc = cyc; end
        if (Rx_EoF) begin n_eof++; if (eof_cyc < 0) eof_cyc = cyc; end
        if (Rx_FrameError) begin n_ferr++; if (ferr_cyc < 0) ferr_cyc = cyc; end
        if (Rx_AbortSignal) begin n_asig++; if (asig_cyc < 0) asig_cyc = cyc; end
        if (prev_vf && !Rx_ValidFrame) begin n_fall++; if (fall_cyc < 0) fall_cyc = cyc; end
        if (Rx_NewByte && !Rx_ValidFrame) n_viol++;
        prev_vf = Rx_ValidFrame;
    endtask

    task automatic do_reset();
        Rx = 1'b1;
        Rst = 1'b1;
        @(posedge Clk);
        @(posedge Clk);
        @(negedge Clk);
        Rst = 1'b0;
    endtask

    task automatic push_raw(input logic b);
        txq.push_back(b);
    endtask

    task automatic push_flag();
        logic [7:0] f;
        f = 8'h7E;
        for (int i = 0; i < 8; i++) push_raw(f[i]);
        ones = 0;
    endtask

    // Transmitter-side zero insertion after five data 1s.
    task automatic push_data(input logic b);
        push_raw(b);
        last_data = txq.size() - 1;
        if (b) begin
            ones++;
            if (ones == 5) begin
                push_raw(1'b0);
                ones = 0;
            end
        end else begin
            ones = 0;
        end
    endtask

    task automatic send_queue(output int c0);
        c0 = -1;
        for (int i = 0; i < txq.size(); i++) begin
            tick(txq[i]);
            if (i == 0) c0 = cyc;
        end
        repeat (14) tick(1'b0);
    endtask

    task automatic run_vec(input vec_t v);
        int f1, fc, ab, ld, c0;
        Rx_Enable = v.en;
        do_reset();
        txq.delete();
        ones = 0; last_data = -1;
        f1 = -1; fc = -1; ab = -1; ld = -1;
        push_raw(1'b0);
        push_raw(1'b0);
        for (int i = 0; i < v.n_open; i++) begin
            push_flag();
            if (f1 < 0) f1 = txq.size() - 1;
        end
        if (v.n_bytes > 0) begin
            for (int i = 0; i < 8; i++) push_data(v.b[i]);
            ld = last_data;
        end
        for (int i = 0; i < v.n_extra; i++) push_data(v.e[i]);
        if (v.tail == 0) begin
            push_flag();
            fc = txq.size() - 1;
        end else begin
            push_raw(1'b0);
            for (int i = 0; i < v.abort_ones; i++) begin
                push_raw(1'b1);
                if (i == 6) ab = txq.size() - 1;
            end
        end
        clear_stats();
        send_queue(c0);

        chk({v.name, ".flag_cnt"}, n_flag, v.x_flag);
        chk({v.name, ".abort_cnt"}, n_abort, v.x_abort);
        chk({v.name, ".newbyte_cnt"}, n_nb, v.x_nb);
        chk({v.name, ".eof_cnt"}, n_eof, v.x_eof);
        chk({v.name, ".ferr_cnt"}, n_ferr, v.x_ferr);
        chk({v.name, ".abortsig_cnt"}, n_asig, v.x_asig);
        chk({v.name, ".vf_fall_cnt"}, n_fall, v.x_fall);
        chk({v.name, ".data"}, int'(Rx_Data), int'(v.x_data));
        chk({v.name, ".newbyte_outside_frame"}, n_viol, 0);
        if (v.x_flag > 0 && f1 >= 0) chk({v.name, ".flag_latency"}, flag_cyc - c0, f1 + 2);
        if (v.x_abort > 0) chk({v.name, ".abort_latency"}, abort_cyc - c0, ab + 2);
        if (v.x_nb > 0) chk({v.name, ".newbyte_latency"}, nb_cyc - c0, ld + 10);
        if (v.x_eof > 0) chk({v.name, ".eof_latency"}, eof_cyc - c0, fc + 4);
        if (v.x_ferr > 0) chk({v.name, ".ferr_latency"}, ferr_cyc - c0, fc + 4);
        if (v.x_asig > 0) chk({v.name, ".abortsig_latency"}, asig_cyc - c0, ab + 3);
        if (v.x_fall > 0) chk({v.name, ".vf_fall_latency"}, fall_cyc - c0,
                              ((v.tail == 0) ? fc : ab) + 3);
    endtask

    vec_t vecs[7];

    initial begin
        int c0;
        //          name             en  op by b      ex e      tl 1s fl ab nb eo fe as fa data
        vecs[0] = '{"flag_a5_flag",  1'b1, 1, 1, 8'hA5, 0, 8'h00, 0, 0, 2, 0, 1, 1, 0, 0, 1, 8'hA5};
        vecs[1] = '{"stuffed_ff",    1'b1, 1, 1, 8'hFF, 0, 8'h00, 0, 0, 2, 0, 1, 1, 0, 0, 1, 8'hFF};
        vecs[2] = '{"abort_3c",      1'b1, 1, 1, 8'h3C, 0, 8'h00, 1, 7, 1, 1, 1, 0, 0, 1, 1, 8'h3C};
        vecs[3] = '{"short_12bit",   1'b1, 1, 1, 8'h96, 4, 8'h03, 0, 0, 2, 0, 1, 0, 1, 0, 1, 8'h96};
        vecs[4] = '{"repeat_flags",  1'b1, 3, 1, 8'h01, 0, 8'h00, 0, 0, 4, 0, 1, 1, 0, 0, 1, 8'h01};
        vecs[5] = '{"enable_off",    1'b0, 1, 1, 8'hA5, 0, 8'h00, 0, 0, 2, 0, 0, 0, 0, 0, 1, 8'hA5};
        vecs[6] = '{"idle_abort_run", 1'b1, 0, 0, 8'h00, 0, 8'h00, 1, 10, 0, 1, 0, 0, 0, 0, 0, 8'h00};

        // Reset must clear outputs before any clock edge.
        #2 Rst = 1'b1;
        #1;
        chk("reset.pulses", int'({Rx_FlagDetect, Rx_AbortDetect, Rx_AbortSignal, Rx_ValidFrame,
                                  Rx_NewByte, Rx_EoF, Rx_FrameError}), 0);
        chk("reset.data", int'(Rx_Data), 0);

        for (int i = 0; i < 7; i++) run_vec(vecs[i]);

        // Asynchronous reset in the middle of the second byte of an open frame.
        Rx_Enable = 1'b1;
        do_reset();
        txq.delete();
        ones = 0;
        push_raw(1'b0);
        push_raw(1'b0);
        push_flag();
        for (int i = 0; i < 8; i++) push_data(c_byte(8'h33, i));
        for (int i = 0; i < 8; i++) push_data(c_byte(8'hC3, i));
        for (int i = 0; i < 4; i++) push_data(c_byte(8'h05, i));
        clear_stats();
        for (int i = 0; i < txq.size(); i++) tick(txq[i]);
        chk("midrst.pre_data", int'(Rx_Data), 8'h33);
        chk("midrst.pre_vf", int'(Rx_ValidFrame), 1);
        chk("midrst.pre_nb_cnt", n_nb, 1);
        Rst = 1'b1;
        #1;
        chk("midrst.async_vf", int'(Rx_ValidFrame), 0);
        chk("midrst.async_data", int'(Rx_Data), 0);
        chk("midrst.async_pulses", int'({Rx_FlagDetect, Rx_AbortDetect, Rx_AbortSignal,
                                         Rx_NewByte, Rx_EoF, Rx_FrameError}), 0);
        @(negedge Clk);
        Rst = 1'b0;

        txq.delete();
        ones = 0;
        push_raw(1'b0);
        push_raw(1'b0);
        push_flag();
        for (int i = 0; i < 8; i++) push_data(c_byte(8'h5A, i));
        push_flag();
        clear_stats();
        send_queue(c0);
        chk("post_rst.newbyte_cnt", n_nb, 1);
        chk("post_rst.data", int'(Rx_Data), 8'h5A);
        chk("post_rst.eof_cnt", n_eof, 1);
        chk("post_rst.abortsig_cnt", n_asig, 0);
        chk("post_rst.ferr_cnt", n_ferr, 0);
        chk("post_rst.newbyte_latency", nb_cyc - c0, 17 + 10);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    function automatic logic c_byte(input logic [7:0] v, input int i);
        return v[i];
    endfunction

endmodule

// File: doc/hdlc_rx_framer.md
HDLC_RX_FRAMER -- requirements
Module: hdlc_rx_framer

Interface
REQ-001 SHALL have one clock and an asynchronous, active-high reset, with ports as follows:
- Clk  in  1  single clock; all logic on posedge
- Rst  in  1  asynchronous, active-high reset
REQ-002 SHALL have the remaining ports:
- Rx_Enable  in  1  gates Rx_NewByte/Rx_EoF generation; detection always runs
- Rx  in  1  serial line, one bit per Clk, LSB of each byte first
- Rx_FlagDetect  out  1  1-cycle pulse, flag 01111110 seen
- Rx_AbortDetect  out  1  1-cycle pulse, abort 0 followed by 1111111 seen
- Rx_AbortSignal  out  1  1-cycle pulse, abort inside a frame
- Rx_ValidFrame  out  1  high while a frame is open
- Rx_Data  out  8  last assembled byte
- Rx_NewByte  out  1  1-cycle pulse, Rx_Data updated
- Rx_EoF  out  1  1-cycle pulse, frame closed normally
- Rx_FrameError  out  1  1-cycle pulse, closing flag not byte-aligned

Function
REQ-003 SHALL register Rx once (Rx_d), then shift it into an 8-bit window each cycle.
REQ-004 SHALL pulse Rx_FlagDetect exactly 2 Clk edges after the edge sampling the final 0 of a flag; the pattern is !Rx ##1 Rx[*6] ##1 !Rx.
REQ-005 SHALL pulse Rx_AbortDetect 2 edges after the edge sampling the seventh consecutive 1 preceded by a 0.
- Further consecutive 1s: no additional pulses until a 0 is seen.
REQ-006 SHALL, after the first Rx_AbortDetect/Rx_ValidFrame=1 cycle, pulse Rx_AbortSignal on the next edge.
- Same edge: Rx_ValidFrame falls, the partial byte is discarded, and no Rx_EoF is issued.
REQ-007 SHALL implement a 2-state frame FSM, IDLE and FRAME:
- IDLE->FRAME on Rx_FlagDetect.
- FRAME->IDLE on a flag with >=1 data byte received (closing), or on abort.
- A flag in FRAME with 0 data bits stays in FRAME (shared/repeated flags).
REQ-008 SHALL drive Rx_ValidFrame=1 in FRAME only.
REQ-009 SHALL, in FRAME, treat a 0 following five consecutive data 1s as a stuffed bit.
- The stuffed 0 is removed: it is not counted and not assembled.
- The 1-run counter resets on any 0 and at frame open.
REQ-010 SHALL take data bits from the output of the 8-bit delay window, so flag bits, abort bits and stuffed zeros never appear in Rx_Data.
REQ-011 SHALL assemble data LSB-first with a 3-bit bit counter; on the 8th data bit it updates Rx_Data and pulses Rx_NewByte (if Rx_Enable=1) in the same cycle.
- Counter wraps 7->0.
- Fixed latency: 10 edges from the edge sampling the byte's last data bit on Rx to Rx_NewByte.
REQ-012 SHALL close a frame as follows:
- Closing flag with bit counter=0: Rx_ValidFrame falls, and Rx_EoF pulses on the following edge (if Rx_Enable=1).
- Closing flag with bit counter!=0: Rx_ValidFrame falls, Rx_FrameError pulses on the following edge, and no Rx_EoF.
REQ-013 SHALL give abort priority when abort and byte completion coincide: no Rx_NewByte is issued.
REQ-014 SHALL, when Rx_Enable=0, keep the FSM and detection running but suppress Rx_NewByte and Rx_EoF; Rx_Data still updates.
REQ-015 SHALL never assert Rx_NewByte, Rx_EoF, Rx_AbortSignal and Rx_FrameError while in IDLE, except the one-edge EoF/FrameError/AbortSignal after FRAME->IDLE.

Reset
REQ-016 SHALL, on Rst=1, immediately clear all of the following, independent of Clk:
- outputs: Rx_FlagDetect, Rx_AbortDetect, Rx_AbortSignal, Rx_ValidFrame, Rx_NewByte, Rx_EoF, Rx_FrameError = 0; Rx_Data = 8'h00.
- internal state: FSM=IDLE; window preloaded to all 1s so no spurious flag is detected; Rx_d=1; counters=0.
REQ-017 SHALL, on Rst asserted mid-frame, emit no Rx_EoF/Rx_AbortSignal; it restarts in IDLE and requires a new opening flag.

Verification
REQ-018 Flag then 8'hA5 then flag, Rx_Enable=1 -> Rx_FlagDetect 2 edges after each flag end; one Rx_NewByte with Rx_Data=8'hA5; Rx_ValidFrame falls; Rx_EoF the next edge.
REQ-019 Frame with byte 8'hFF (transmitted 11111011 1, stuffed) -> Rx_Data=8'hFF; no Rx_FlagDetect/Rx_AbortDetect inside the frame.
REQ-020 Flag, 8'h3C, then 0 followed by seven 1s -> Rx_AbortDetect; Rx_AbortSignal next edge; Rx_ValidFrame=0; no Rx_EoF; exactly one Rx_NewByte.
REQ-021 Flag, 12 data bits, flag -> Rx_FrameError pulse, no Rx_EoF, Rx_NewByte exactly once.
REQ-022 Flag, flag, flag, 8'h01, flag -> Rx_ValidFrame stays high across repeated flags; single Rx_EoF.
REQ-023 Rst pulse mid-byte of an open frame -> all outputs 0 asynchronously; a following frame 8'h5A decodes correctly with no stale bits.
